// File: rtl/johnson_phase_decoder.sv
// Registers 4-bit Johnson counter codes and decodes them into a phase index and one-hot strobe.
// Also checks sequence legality, flags errors, and counts completed revolutions.
module johnson_phase_decoder #(
    parameter int REV_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             n0,
    input  logic             n1,
    input  logic             n2,
    input  logic             n3,
    input  logic             clr_err,
    output logic [2:0]       phase,
    output logic [7:0]       onehot,
    output logic             valid,
    output logic             wrap,
    output logic [REV_W-1:0] rev_count,
    output logic             illegal,
    output logic             seq_err
);

    logic [3:0]       code;
    logic             code_legal;
    logic [2:0]       code_phase;

    logic             primed;
    logic [2:0]       phase_d;
    logic             valid_d;
    logic             primed_d;
    logic             wrap_d;
    logic [REV_W-1:0] rev_d;
    logic             ill_set;
    logic             seq_set;

    assign code = {n0, n1, n2, n3};

    always_comb begin
        code_legal = 1'b1;
        code_phase = 3'd0;
        case (code)
            4'b0000: code_phase = 3'd0;
            4'b1000: code_phase = 3'd1;
            4'b1100: code_phase = 3'd2;
            4'b1110: code_phase = 3'd3;
            4'b1111: code_phase = 3'd4;
            4'b0111: code_phase = 3'd5;
            4'b0011: code_phase = 3'd6;
            4'b0001: code_phase = 3'd7;
            default: code_legal = 1'b0;
        endcase
    end

    // NOTE: every signal gets a default before the branches so no path leaves it unassigned (no latches).
    always_comb begin
        phase_d  = phase;
        valid_d  = valid;
        primed_d = primed;
        wrap_d   = 1'b0;
        rev_d    = rev_count;
        ill_set  = 1'b0;
        seq_set  = 1'b0;
        if (en) begin
            if (!code_legal) begin
                ill_set  = 1'b1;
                valid_d  = 1'b0;
                primed_d = 1'b0;
            end else if (!primed) begin
                phase_d  = code_phase;
                valid_d  = 1'b1;
                primed_d = 1'b1;
            end else if (code_phase == phase + 3'd1) begin
                phase_d = code_phase;
                if (phase == 3'd7) begin
                    wrap_d = 1'b1;
                    rev_d  = rev_count + REV_W'(1);
                end
            end else if (code_phase != phase) begin
                // Resynchronise to the observed phase after a skip.
                seq_set = 1'b1;
                phase_d = code_phase;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase     <= 3'd0;
            valid     <= 1'b0;
            primed    <= 1'b0;
            wrap      <= 1'b0;
            rev_count <= '0;
            illegal   <= 1'b0;
            seq_err   <= 1'b0;
        end else begin
            phase     <= phase_d;
            valid     <= valid_d;
            primed    <= primed_d;
            wrap      <= wrap_d;
            rev_count <= rev_d;
            // A newly detected error outranks a same-cycle clear.
            illegal   <= ill_set | (illegal & ~clr_err);
            seq_err   <= seq_set | (seq_err & ~clr_err);
        end
    end

    assign onehot = valid ? (8'd1 << phase) : 8'd0;

endmodule

// File: tb/tb_johnson_phase_decoder.sv
// Self-checking bench for johnson_phase_decoder: a phase-table reference model checked every cycle,
// plus hand-computed literal expectations for the directed scenarios.
module tb_johnson_phase_decoder;

    localparam int REV_W = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             en = 1'b0;
    logic             n0 = 1'b0, n1 = 1'b0, n2 = 1'b0, n3 = 1'b0;
    logic             clr_err = 1'b0;
    logic [2:0]       phase;
    logic [7:0]       onehot;
    logic             valid;
    logic             wrap;
    logic [REV_W-1:0] rev_count;
    logic             illegal;
    logic             seq_err;

    johnson_phase_decoder #(.REV_W(REV_W)) dut (
        .clk(clk), .reset(reset), .en(en),
        .n0(n0), .n1(n1), .n2(n2), .n3(n3),
        .clr_err(clr_err),
        .phase(phase), .onehot(onehot), .valid(valid), .wrap(wrap),
        .rev_count(rev_count), .illegal(illegal), .seq_err(seq_err)
    );

    always #5 clk = ~clk;

    // Legal Johnson codes indexed by phase.
    logic [3:0] legal_codes [8] = '{4'b0000, 4'b1000, 4'b1100, 4'b1110,
                                    4'b1111, 4'b0111, 4'b0011, 4'b0001};

    int n_vec  = 0;
    int n_fail = 0;

    // Reference model state
    int m_phase, m_rev, m_wraps;
    bit m_valid, m_primed, m_wrap, m_ill, m_seq;
    int dut_wraps = 0;

    task automatic check(input string name, input longint actual, input longint expected);
        n_vec++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    function automatic int lookup(input logic [3:0] c);
        for (int i = 0; i < 8; i++)
            if (legal_codes[i] == c) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_rev = 0; m_valid = 0; m_primed = 0;
        m_wrap = 0; m_ill = 0; m_seq = 0;
    endtask

    task automatic model_step(input bit e, input logic [3:0] c, input bit clr);
        int idx;
        bit set_ill, set_seq;
        set_ill = 0; set_seq = 0; m_wrap = 0;
        if (e) begin
            idx = lookup(c);
            if (idx < 0) begin
                set_ill = 1; m_valid = 0; m_primed = 0;
            end else if (!m_primed) begin
                m_phase = idx; m_valid = 1; m_primed = 1;
            end else if (idx == (m_phase + 1) % 8) begin
                if (m_phase == 7) begin
                    m_wrap = 1;
                    m_rev = (m_rev + 1) % (1 << REV_W);
                    m_wraps++;
                end
                m_phase = idx;
            end else if (idx != m_phase) begin
                set_seq = 1; m_phase = idx;
            end
        end
        if (set_ill) m_ill = 1; else if (clr) m_ill = 0;
        if (set_seq) m_seq = 1; else if (clr) m_seq = 0;
    endtask

    // Single compare routine: every DUT output against the model.
    task automatic compare_all();
        check("phase", phase, m_phase);
        check("valid", valid, m_valid);
        check("onehot", onehot, m_valid ? (1 << m_phase) : 0);
        check("wrap", wrap, m_wrap);
        check("rev_count", rev_count, m_rev);
        check("illegal", illegal, m_ill);
        check("seq_err", seq_err, m_seq);
    endtask

    task automatic step(input bit e, input logic [3:0] c, input bit clr);
        @(negedge clk);
        en = e; {n0, n1, n2, n3} = c; clr_err = clr;
        @(posedge clk);
        #1;
        model_step(e, c, clr);
        if (wrap) dut_wraps++;
        compare_all();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0; en = 1'b0; clr_err = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        model_reset();
        m_wraps = 0;

        // 1. reset, then one full revolution
        do_reset();
        check("reset_phase", phase, 0);
        check("reset_onehot", onehot, 8'h00);
        for (int i = 0; i < 9; i++) begin
            step(1, legal_codes[i % 8], 0);
            check("t1_onehot", onehot, 8'h01 << (i % 8));
        end
        check("t1_rev", rev_count, 1);
        check("t1_wraps", dut_wraps, 1);
        check("t1_seq", seq_err, 0);

        // 2. 256 revolutions from a fresh reset
        do_reset();
        dut_wraps = 0; m_wraps = 0;
        step(1, 4'b0000, 0);
        for (int i = 0; i < 256 * 8; i++) step(1, legal_codes[(i + 1) % 8], 0);
        check("t2_rev", rev_count, 0);
        check("t2_wraps", dut_wraps, 256);
        check("t2_model_wraps", m_wraps, 256);

        // 3. skip 1100 -> 1111
        step(1, 4'b1000, 0);
        step(1, 4'b1100, 0);
        step(1, 4'b1111, 0);
        check("t3_seq", seq_err, 1);
        check("t3_phase", phase, 4);
        step(1, 4'b0111, 0);
        check("t3_phase5", phase, 5);
        step(0, 4'b0111, 1);
        check("t3_clr", seq_err, 0);

        // 4. illegal code breaks the chain; next legal code re-primes
        step(1, 4'b0011, 0);
        step(1, 4'b0001, 0);
        step(1, 4'b0000, 0);
        step(1, 4'b1000, 0);
        step(1, 4'b1100, 0);
        step(1, 4'b1110, 0);
        step(1, 4'b1010, 0);
        check("t4_illegal", illegal, 1);
        check("t4_valid", valid, 0);
        check("t4_onehot", onehot, 8'h00);
        check("t4_phase", phase, 3);
        step(1, 4'b0011, 0);
        check("t4_phase6", phase, 6);
        check("t4_seq", seq_err, 0);

        // 5. en = 0 ignores inputs; set beats clear
        step(1, 4'b0011, 1);
        check("t5_clr", illegal, 0);
        step(0, 4'b1010, 0);
        step(0, 4'b0101, 0);
        step(0, 4'b1111, 0);
        check("t5_hold_phase", phase, 6);
        check("t5_hold_valid", valid, 1);
        check("t5_hold_ill", illegal, 0);
        check("t5_hold_seq", seq_err, 0);
        step(1, 4'b1001, 1);
        check("t5_set_wins", illegal, 1);

        // 6. asynchronous reset at phase 5 with rev_count = 3
        do_reset();
        step(1, 4'b0000, 0);
        for (int i = 0; i < 3 * 8 + 5; i++) step(1, legal_codes[(i + 1) % 8], 0);
        check("t6_pre_phase", phase, 5);
        check("t6_pre_rev", rev_count, 3);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check("t6_async_phase", phase, 0);
        check("t6_async_rev", rev_count, 0);
        check("t6_async_valid", valid, 0);
        @(posedge clk);
        #1;
        compare_all();
        @(negedge clk);
        reset = 1'b1;
        step(1, 4'b0011, 0);
        check("t6_phase", phase, 6);
        check("t6_seq", seq_err, 0);
        check("t6_valid", valid, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/johnson_phase_decoder.md
Name: johnson_phase_decoder

Overview:
- Downstream consumer of the 4-bit Johnson counter outputs n0..n3.
- Registers each sampled code and decodes it into a 3-bit phase index and an 8-bit one-hot phase strobe.
- Checks that successive codes follow the legal Johnson sequence and counts completed revolutions (phase 7 -> 0).
- Feeds phase-timed logic; flags corrupted or skipped codes.

Parameters:
REV_W, 8, width of the revolution counter rev_count (wraps modulo 2^REV_W)

Ports:
clk  input  1  system clock, rising-edge active
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
en  input  1  sample enable; when 0 the inputs are ignored
n0  input  1  Johnson bit 0 (MSB of code)
n1  input  1  Johnson bit 1
n2  input  1  Johnson bit 2
n3  input  1  Johnson bit 3 (LSB of code)
clr_err  input  1  synchronous clear of the sticky error flags
phase  output  3  decoded phase index 0..7
onehot  output  8  onehot[phase] = 1 while valid = 1, otherwise all zero
valid  output  1  the last sampled code was legal
wrap  output  1  one-cycle pulse on a 7 -> 0 transition
rev_count  output  REV_W  number of completed revolutions
illegal  output  1  sticky: an illegal code was sampled
seq_err  output  1  sticky: a legal code broke the sequence

Behaviour:
- Code is {n0,n1,n2,n3}. Legal sequence, phases 0..7: 0000, 1000, 1100, 1110, 1111, 0111, 0011, 0001, then back to 0000.
- The remaining 8 codes are illegal.
- Reset (reset = 0, asynchronous): all outputs are 0, the internal primed flag is 0, and the previous phase is 0.
- Latency: one clock. The code sampled at edge k appears on the outputs after edge k.
- en = 0: phase, onehot, valid, rev_count and the sticky flags hold. wrap = 0. No checks are made.
- en = 1, legal code, primed = 0:
  - Load phase and set valid = 1.
  - Set primed = 1.
  - No sequence check is made and no wrap is generated.
- en = 1, legal code, primed = 1:
  - Same phase as before: hold, no error.
  - Phase = previous phase + 1 (mod 8): update phase. If the previous phase was 7 and the new phase is 0, pulse wrap and increment rev_count, wrapping from all-ones to 0.
  - Any other phase: set seq_err, load the new phase (resynchronise), no wrap, rev_count unchanged.
- en = 1, illegal code:
  - Set illegal; valid = 0 and onehot = 0.
  - phase holds its last value.
  - primed = 0, so the next legal code re-primes without a sequence check.
- clr_err = 1 clears illegal and seq_err on the next edge. If an error is detected in the same cycle, the set wins and the flag stays 1.
- clr_err is independent of en.
- wrap is high for exactly one cycle per detected wrap and is never high while valid = 0.
- Reset asserted mid-operation clears everything immediately, including rev_count and the sticky flags. After reset is released, the first legal code re-primes without a check.

Test Plan:
1. Hold reset = 0, then release it. Drive 0000, 1000, …, 0001, 0000 with en = 1.
   - phase steps 0..7 then 0; onehot goes 01h, 02h, …, 80h, 01h.
   - A single wrap pulse occurs; rev_count = 1; no error flags.
2. Run 256 full revolutions with REV_W = 8.
   - rev_count ends at 0 (wrapped); wrap pulsed 256 times.
3. Drive 1100 then 1111 (skip).
   - seq_err = 1 and phase = 4.
   - Then 0111: phase = 5 with no new error.
   - Pulse clr_err: seq_err returns to 0.
4. Drive legal 1110, then illegal 1010, then 0011.
   - On 1010: illegal = 1, valid = 0, onehot = 00h, phase holds 3.
   - On 0011: phase = 6, seq_err stays 0 because of the re-prime.
5. Toggle en = 0 mid-sequence while driving illegal codes.
   - All outputs hold and no flags set.
   - Drive clr_err and an error-causing code in the same cycle: the flag remains 1.
6. Pull reset low at phase 5 with rev_count = 3.
   - Outputs immediately 0.
   - After release, the first code 0011 gives phase = 6 and seq_err = 0.
